pingpong_sched: RTL
===================

// Module: pingpong_sched
// PURPOSE
//  Command scheduler for the 4-bit pingpong up/down counter. Round-robin arbitrates NUM_REQ requesters.
//  Executes the granted command by driving the counter's hold/flip inputs.
//  Reports completion, steps taken and status. Sits between software-facing requesters and one counter.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2); ID_W = $clog2(NUM_REQ), local
//  ARG_W    8  width of command argument / step count
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            reset, asynchronous, active-low
//  req_valid    in   NUM_REQ      per-requester command valid, held until req_ready
//  req_cmd      in   2*NUM_REQ    per-requester cmd; slice i = [2i+1:2i]
//  req_arg      in   ARG_W*NUM_REQ per-requester argument (cycle/step count)
//  req_ready    out  NUM_REQ      one-hot accept pulse, 1 cycle
//  abort        in   1            synchronous abort of the executing command
//  cnt_out      in   4            counter value
//  cnt_dir      in   1            counter direction (0 up, 1 down)
//  cnt_max      in   1            counter == 15
//  cnt_min      in   1            counter == 0
//  cnt_hold     out  1            to counter hold
//  cnt_flip     out  1            to counter flip
//  busy         out  1            state != IDLE
//  done         out  1            1-cycle completion pulse
//  done_id      out  ID_W         requester index of completed command
//  done_status  out  2            00 OK, 01 EXT_REACHED, 10 FLIP_IGNORED, 11 ABORTED
//  done_steps   out  ARG_W        counter steps taken (cycles with cnt_hold=0)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, cnt_hold=1, cnt_flip=0, req_ready=0, busy=0, done=0.
//  Reset also clears done_id/status/steps to 0. Reset mid-command drops the command; no done is issued.
//  FSM states: IDLE, RUN, RUNX, HOLDN, FLIP, DONE.
//  cnt_hold = 0 only in RUN, RUNX, FLIP. cnt_flip = 1 only in FLIP. Both are combinational decodes of state.
//  Arbitration runs only in IDLE. The first valid index at or after ptr (mod NUM_REQ) wins.
//  The winner gets req_ready=1 in that cycle (combinational from req_valid). Cmd/arg are latched; ptr <= winner+1 mod NUM_REQ.
//  Commands, accepted at cycle T:
//   00 RUN_N:   RUN for arg cycles (T+1..T+arg), then DONE, status OK.
//   01 RUN_EXT: RUNX until arg cycles elapse, or the counter reaches 15/0.
//               The last stepping cycle is the one where (cnt_out==14 && !cnt_dir) or (cnt_out==1 && cnt_dir) -> status EXT_REACHED.
//               Otherwise the command ends on arg cycles with status OK.
//   10 HOLD_N:  HOLDN for arg cycles with cnt_hold=1 (reserves counter), steps=0, status OK.
//   11 FLIP:    exactly 1 FLIP cycle (arg ignored), steps=1.
//               Status FLIP_IGNORED if cnt_out is 1 or 14 in that cycle, else OK.
//  arg==0 for RUN_N/RUN_EXT/HOLD_N: go directly to DONE at T+1, steps=0, status OK.
//  DONE lasts 1 cycle: done=1, with done_id/status/steps valid (registered, held until next DONE). Then IDLE.
//  Throughput: next accept is earliest at T+arg+2 (IDLE after DONE). No accept in DONE.
//  abort high in any RUN/RUNX/HOLDN/FLIP cycle: that cycle still executes and counts.
//   Next state is DONE with status ABORTED; abort takes precedence over normal/extreme completion the same cycle.
//   abort in IDLE/DONE is ignored.
//  Step counter: ARG_W bits, cleared at accept, +1 per RUN/RUNX/FLIP cycle. It never exceeds arg, so no wrap.
//  req_valid dropped before grant is legal; no state is kept for ungranted requests.
// TESTING
//  1. Reset; req0 RUN_N arg=5, counter at 0 up -> req_ready[0] at T, cnt_hold=0 T+1..T+5, done at T+6, steps=5, cnt_out=5.
//  2. req0..req3 all valid RUN_N arg=1 continuously -> grants in order 0,1,2,3,0; each done_id matches; accepts 3 cycles apart.
//  3. cnt_out=12 up, RUN_EXT arg=10 -> 3 steps, counter ends at 15, done_status=01, done_steps=3.
//  4. FLIP with cnt_out=14 -> status 10, steps 1. FLIP with cnt_out=7 up -> status 00, counter dir=1.
//  5. RUN_N arg=20, abort at 4th exec cycle -> done next cycle, status 11, steps 4. A subsequent request is accepted normally.
//  6. rst_n low during HOLDN -> outputs at reset values immediately, no done; RUN_N arg=0 -> done at T+1, steps 0.

Source files
------------

// File: rtl/pingpong_sched.sv
// pingpong_sched: round-robin command scheduler in front of a 4-bit pingpong counter.
// Grants one requester at a time, drives the counter's hold/flip controls while the
// command executes, then reports completion id, status and the number of steps taken.
module pingpong_sched #(
  parameter int unsigned  NUM_REQ = 4,
  parameter int unsigned  ARG_W   = 8,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_cmd,
  input  logic [ARG_W*NUM_REQ-1:0] req_arg,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     abort,
  input  logic [3:0]               cnt_out,
  input  logic                     cnt_dir,
  input  logic                     cnt_max,
  input  logic                     cnt_min,
  output logic                     cnt_hold,
  output logic                     cnt_flip,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [1:0]               done_status,
  output logic [ARG_W-1:0]         done_steps
);

  typedef enum logic [2:0] {IDLE, RUN, RUNX, HOLDN, FLIP, DONE} state_t;

  localparam logic [1:0] CMD_RUN_N   = 2'b00;
  localparam logic [1:0] CMD_RUN_EXT = 2'b01;
  localparam logic [1:0] CMD_HOLD_N  = 2'b10;
  localparam logic [1:0] CMD_FLIP    = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EXT     = 2'b01;
  localparam logic [1:0] ST_IGNORED = 2'b10;
  localparam logic [1:0] ST_ABORTED = 2'b11;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic [ARG_W-1:0]  rem;
  logic [ARG_W-1:0]  steps;

  logic              grant;
  logic [ID_W-1:0]   win;
  logic [31:0]       idx;
  logic [1:0]        win_cmd;
  logic [ARG_W-1:0]  win_arg;
  logic [ID_W-1:0]   ptr_nxt;

  logic              exec;
  logic              stepping;
  logic              ext_c;
  logic              fin;
  logic [1:0]        fin_status;
  logic [ID_W-1:0]   fin_id;
  logic [ARG_W-1:0]  fin_steps;

  // The extreme flags duplicate information already carried by cnt_out/cnt_dir.
  logic              unused_cnt_flags;
  assign unused_cnt_flags = cnt_max ^ cnt_min;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant && req_valid[ID_W'(idx)]) begin
        grant = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign win_cmd = req_cmd[{win, 1'b0} +: 2];
  assign win_arg = req_arg[32'(win) * ARG_W +: ARG_W];
  assign ptr_nxt = ID_W'((32'(win) + 32'd1) % NUM_REQ);

  // Accept pulse is a combinational decode of the winner while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant) req_ready[win] = 1'b1;
  end

  // Counter control decodes.
  assign stepping = (state == RUN) || (state == RUNX) || (state == FLIP);
  assign exec     = stepping || (state == HOLDN);
  assign cnt_hold = !stepping;
  assign cnt_flip = (state == FLIP);

  // This cycle is the last stepping cycle before the counter hits 15 (up) or 0 (down).
  assign ext_c = (cnt_out == 4'd14 && !cnt_dir) || (cnt_out == 4'd1 && cnt_dir);

  // Completion decision for the current cycle; abort overrides any other outcome.
  always_comb begin
    fin        = 1'b0;
    fin_status = ST_OK;
    fin_id     = id_q;
    fin_steps  = steps;
    case (state)
      IDLE: begin
        if (grant && win_cmd != CMD_FLIP && win_arg == '0) begin
          fin       = 1'b1;
          fin_id    = win;
          fin_steps = '0;
        end
      end
      RUN, HOLDN: fin = (rem == ARG_W'(1));
      RUNX: begin
        if (ext_c) begin
          fin        = 1'b1;
          fin_status = ST_EXT;
        end else begin
          fin = (rem == ARG_W'(1));
        end
      end
      FLIP: begin
        fin = 1'b1;
        if (cnt_out == 4'd1 || cnt_out == 4'd14) fin_status = ST_IGNORED;
      end
      default: ;
    endcase
    if (stepping) fin_steps = steps + ARG_W'(1);
    if (abort && exec) begin
      fin        = 1'b1;
      fin_status = ST_ABORTED;
    end
  end

  // Scheduler FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      rem         <= '0;
      steps       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      done_status <= ST_OK;
      done_steps  <= '0;
    end else begin
      done <= 1'b0;
      if (fin) begin
        state       <= DONE;
        done        <= 1'b1;
        done_id     <= fin_id;
        done_status <= fin_status;
        done_steps  <= fin_steps;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            id_q  <= win;
            rem   <= win_arg;
            steps <= '0;
            ptr   <= ptr_nxt;
            busy  <= 1'b1;
            if (!fin) begin
              case (win_cmd)
                CMD_RUN_N:   state <= RUN;
                CMD_RUN_EXT: state <= RUNX;
                CMD_HOLD_N:  state <= HOLDN;
                default:     state <= FLIP;
              endcase
            end
          end
        end
        RUN, RUNX, HOLDN, FLIP: begin
          rem <= rem - ARG_W'(1);
          if (stepping) steps <= steps + ARG_W'(1);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
